// File: rtl/regfile_signext.sv
// Decode-stage GPR file (two combinational read ports, one synchronous write port,
// $0 hardwired to zero, write-through bypass) plus the I-type immediate sign-extender.
module regfile_signext #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int IMM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enabled,
    output logic [DATA_WIDTH-1:0] data_1,
    output logic [DATA_WIDTH-1:0] data_2,
    input  logic [IMM_WIDTH-1:0]  imm_in,
    output logic [DATA_WIDTH-1:0] imm_out
);

    localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int EXT_WIDTH = DATA_WIDTH - IMM_WIDTH;

    logic [DATA_WIDTH-1:0] gpr [NUM_REGS];
    logic                  write_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (write_enabled && (write_addr != '0)) begin
            gpr[write_addr] <= write_data;
        end
    end

    // Bypass is suppressed during reset so both ports read 0 while rst_n is low.
    assign write_live = rst_n && write_enabled && (write_addr != '0);

    always_comb begin
        data_1 = '0;
        if (read_addr_1 != '0) begin
            if (write_live && (write_addr == read_addr_1)) begin
                data_1 = write_data;
            end else begin
                data_1 = gpr[read_addr_1];
            end
        end
    end

    always_comb begin
        data_2 = '0;
        if (read_addr_2 != '0) begin
            if (write_live && (write_addr == read_addr_2)) begin
                data_2 = write_data;
            end else begin
                data_2 = gpr[read_addr_2];
            end
        end
    end

    assign imm_out = {{EXT_WIDTH{imm_in[IMM_WIDTH-1]}}, imm_in};

endmodule

// File: tb/tb_regfile_signext.sv
// Self-checking bench for regfile_signext: directed feature tests plus a random
// stream checked through an expected-value queue against a behavioural model.
module tb_regfile_signext;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_addr_1;
    logic [4:0]  read_addr_2;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_enabled;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic [15:0] imm_in;
    logic [31:0] imm_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [32];

    localparam logic [15:0] IMM_VEC [6] = '{16'h0005, 16'h7FFF, 16'h8000, 16'hFFFC, 16'hFFFF, 16'h0000};
    localparam logic [31:0] IMM_EXP [6] = '{32'h00000005, 32'h00007FFF, 32'hFFFF8000,
                                            32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000000};

    regfile_signext dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_addr_1  (read_addr_1),
        .read_addr_2  (read_addr_2),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enabled(write_enabled),
        .data_1       (data_1),
        .data_2       (data_2),
        .imm_in       (imm_in),
        .imm_out      (imm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        write_enabled = 1'b1;
        write_addr    = addr;
        write_data    = data;
        @(posedge clk);
        #1;
        write_enabled = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        do_write(5'd5, 32'h00001234);
        @(negedge clk);
        read_addr_1 = 5'd5;
        exp_q.push_back(32'h00001234);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL reset_preload: data_1=%h expected %h", data_1, e);
        end
        #1;
        rst_n = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL reset_async_clear: data_1=%h expected %h", data_1, e);
        end
        write_enabled = 1'b1;
        write_addr    = 5'd5;
        write_data    = 32'hAAAA5555;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL reset_no_bypass: data_1=%h expected %h", data_1, e);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL reset_write_ignored: data_1=%h expected %h", data_1, e);
        end
        @(negedge clk);
        write_enabled = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            read_addr_1 = 5'(i);
            read_addr_2 = 5'(31 - i);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (data_1 !== e) begin
                errors++;
                $display("[TB] FAIL reset_all_p1 r%0d: data_1=%h expected %h", i, data_1, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (data_2 !== e) begin
                errors++;
                $display("[TB] FAIL reset_all_p2 r%0d: data_2=%h expected %h", 31 - i, data_2, e);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        do_write(5'd7, 32'hDEADBEEF);
        do_write(5'd31, 32'h00000001);
        @(negedge clk);
        read_addr_1 = 5'd7;
        read_addr_2 = 5'd31;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h00000001);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL wr_r7_p1: data_1=%h expected %h", data_1, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (data_2 !== e) begin
            errors++;
            $display("[TB] FAIL wr_r31_p2: data_2=%h expected %h", data_2, e);
        end
        read_addr_1 = 5'd31;
        read_addr_2 = 5'd7;
        exp_q.push_back(32'h00000001);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL wr_r31_p1: data_1=%h expected %h", data_1, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (data_2 !== e) begin
            errors++;
            $display("[TB] FAIL wr_r7_p2: data_2=%h expected %h", data_2, e);
        end
        read_addr_1 = 5'd7;
        read_addr_2 = 5'd7;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL wr_same_p1: data_1=%h expected %h", data_1, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (data_2 !== e) begin
            errors++;
            $display("[TB] FAIL wr_same_p2: data_2=%h expected %h", data_2, e);
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] e;
        @(negedge clk);
        write_enabled = 1'b1;
        write_addr    = 5'd0;
        write_data    = 32'hFFFFFFFF;
        read_addr_1   = 5'd0;
        read_addr_2   = 5'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL zero_no_bypass: data_1=%h expected %h", data_1, e);
        end
        @(posedge clk);
        #1;
        write_enabled = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL zero_after_write: data_1=%h expected %h", data_1, e);
        end
        @(negedge clk);
        write_enabled = 1'b0;
        write_addr    = 5'd9;
        write_data    = 32'h00000055;
        read_addr_1   = 5'd9;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL we0_no_bypass: data_1=%h expected %h", data_1, e);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL we0_unchanged: data_1=%h expected %h", data_1, e);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        do_write(5'd3, 32'h00000011);
        do_write(5'd4, 32'h00000044);
        @(negedge clk);
        write_enabled = 1'b1;
        write_addr    = 5'd3;
        write_data    = 32'h00000022;
        read_addr_1   = 5'd3;
        read_addr_2   = 5'd4;
        exp_q.push_back(32'h00000022);
        exp_q.push_back(32'h00000044);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL bypass_before_edge: data_1=%h expected %h", data_1, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (data_2 !== e) begin
            errors++;
            $display("[TB] FAIL bypass_other_reg: data_2=%h expected %h", data_2, e);
        end
        read_addr_2 = 5'd3;
        exp_q.push_back(32'h00000022);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_2 !== e) begin
            errors++;
            $display("[TB] FAIL bypass_port2: data_2=%h expected %h", data_2, e);
        end
        @(posedge clk);
        #1;
        write_enabled = 1'b0;
        exp_q.push_back(32'h00000022);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (data_1 !== e) begin
            errors++;
            $display("[TB] FAIL bypass_after_edge: data_1=%h expected %h", data_1, e);
        end
    endtask

    task automatic test_sign_extend();
        logic [31:0] e;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            rst_n = (pass == 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < 6; i++) begin
                imm_in = IMM_VEC[i];
                exp_q.push_back(IMM_EXP[i]);
                #1;
                e = exp_q.pop_front();
                checks++;
                if (imm_out !== e) begin
                    errors++;
                    $display("[TB] FAIL signext rst_n=%0b imm=%h: imm_out=%h expected %h",
                             rst_n, imm_in, imm_out, e);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic [31:0] exp1;
        logic [31:0] exp2;
        @(negedge clk);
        write_enabled = 1'b0;
        rst_n = 1'b0;
        for (int r = 0; r < 32; r++) model[r] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (cyc == 500) begin
                rst_n = 1'b0;
                for (int r = 0; r < 32; r++) model[r] = 32'h0;
            end else if (cyc == 504) begin
                rst_n = 1'b1;
            end
            write_enabled = 1'($urandom_range(0, 1));
            write_addr    = 5'($urandom_range(0, 31));
            write_data    = $urandom;
            read_addr_1   = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            read_addr_2   = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
            imm_in        = 16'($urandom);
            exp1 = 32'h0;
            exp2 = 32'h0;
            if (rst_n && read_addr_1 != 5'd0) begin
                if (write_enabled && write_addr != 5'd0 && write_addr == read_addr_1) exp1 = write_data;
                else exp1 = model[read_addr_1];
            end
            if (rst_n && read_addr_2 != 5'd0) begin
                if (write_enabled && write_addr != 5'd0 && write_addr == read_addr_2) exp2 = write_data;
                else exp2 = model[read_addr_2];
            end
            exp_q.push_back(exp1);
            exp_q.push_back(exp2);
            exp_q.push_back({{16{imm_in[15]}}, imm_in});
            #1;
            e = exp_q.pop_front();
            checks++;
            if (data_1 !== e) begin
                errors++;
                $display("[TB] FAIL rand_p1 cyc%0d addr=%0d: data_1=%h expected %h", cyc, read_addr_1, data_1, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (data_2 !== e) begin
                errors++;
                $display("[TB] FAIL rand_p2 cyc%0d addr=%0d: data_2=%h expected %h", cyc, read_addr_2, data_2, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (imm_out !== e) begin
                errors++;
                $display("[TB] FAIL rand_imm cyc%0d: imm_out=%h expected %h", cyc, imm_out, e);
            end
            @(posedge clk);
            if (rst_n && write_enabled && write_addr != 5'd0) model[write_addr] = write_data;
        end
        @(negedge clk);
        write_enabled = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        read_addr_1   = '0;
        read_addr_2   = '0;
        write_addr    = '0;
        write_data    = '0;
        write_enabled = 1'b0;
        imm_in        = '0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] starting directed tests");
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_sign_extend();
        $display("[TB] starting random stream");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
